// File: rtl/dense_pkg.sv
// dense_pkg: shared widths and state encoding for the dense-layer sequencer
package dense_pkg;
  localparam int N_PE    = 16;
  localparam int LEN_W   = 16;
  localparam int TILE_W  = 12;
  localparam int MAC_LAT = 3;
  localparam int ADDR_W  = $clog2(N_PE);
  localparam int LAT_W   = $clog2(MAC_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, LATCH, READ, NEXT, DONE} dense_state_e;
endpackage

// File: rtl/dense_cfg_check.sv
// dense_cfg_check: config legality check and per-PE mask from active_pes
module dense_cfg_check
  import dense_pkg::*;
(
  input  logic [LEN_W-1:0]  in_len_i,
  input  logic [TILE_W-1:0] num_tiles_i,
  input  logic [ADDR_W:0]   active_pes_i,
  output logic              legal_o,
  output logic [N_PE-1:0]   mask_o
);
  assign legal_o = |in_len_i && |num_tiles_i && |active_pes_i &&
                   active_pes_i <= (ADDR_W+1)'(N_PE);
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < N_PE; i++) mask_o[i] = i < int'(active_pes_i);
  end
endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: per-tile clear/accumulate/drain/latch/read sequencer for dense layers
module dense_seq_ctrl
  import dense_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  in_len_i,
  input  logic [TILE_W-1:0] num_tiles_i,
  input  logic [ADDR_W:0]   active_pes_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              dense_enable_o,
  output logic              dense_valid_o,
  output logic [N_PE-1:0]   dense_adder_reset_o,
  output logic [N_PE-1:0]   dense_adder_on_o,
  output logic              dense_latch_o,
  output logic [ADDR_W-1:0] dense_rd_addr_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o
);
  dense_state_e      state_q;
  logic [LEN_W-1:0]  len_q, beat_q;
  logic [TILE_W-1:0] tiles_q, tile_q;
  logic [ADDR_W:0]   ap_q, rd_q;
  logic [LAT_W-1:0]  lat_q;
  logic [N_PE-1:0]   mask_d, mask_q;
  logic              legal, cfg_err_q;
  dense_cfg_check u_cfg_check (
    .in_len_i     (in_len_i),
    .num_tiles_i  (num_tiles_i),
    .active_pes_i (active_pes_i),
    .legal_o      (legal),
    .mask_o       (mask_d)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      tiles_q   <= '0;
      tile_q    <= '0;
      ap_q      <= '0;
      rd_q      <= '0;
      lat_q     <= '0;
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
    end else if (abort_i) begin
      state_q   <= IDLE;
      tile_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          len_q     <= in_len_i;
          tiles_q   <= num_tiles_i;
          ap_q      <= active_pes_i;
          mask_q    <= mask_d;
          cfg_err_q <= !legal;
          state_q   <= legal ? CLEAR : DONE;
        end
        CLEAR: begin
          beat_q  <= '0;
          state_q <= ACCUM;
        end
        ACCUM: if (in_valid_i) begin
          // the final beat is consumed here; the counter never wraps past in_len-1
          if (beat_q == len_q - 1'b1) begin
            lat_q   <= '0;
            state_q <= DRAIN;
          end else beat_q <= beat_q + 1'b1;
        end
        DRAIN: begin
          if (lat_q == LAT_W'(MAC_LAT - 1)) state_q <= LATCH;
          else lat_q <= lat_q + 1'b1;
        end
        LATCH: begin
          rd_q    <= '0;
          state_q <= READ;
        end
        READ: if (out_ready_i) begin
          if (rd_q == ap_q - 1'b1) state_q <= NEXT;
          else rd_q <= rd_q + 1'b1;
        end
        NEXT: begin
          if (tile_q == tiles_q - 1'b1) state_q <= DONE;
          else begin
            tile_q  <= tile_q + 1'b1;
            state_q <= CLEAR;
          end
        end
        DONE: begin
          tile_q    <= '0;
          cfg_err_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o              = state_q != IDLE;
  assign dense_enable_o      = state_q inside {CLEAR, ACCUM, DRAIN, LATCH, READ};
  assign in_ready_o          = state_q == ACCUM;
  assign dense_valid_o       = state_q == ACCUM && in_valid_i;
  assign dense_adder_reset_o = state_q == CLEAR ? mask_q : '0;
  assign dense_adder_on_o    = state_q inside {ACCUM, DRAIN} ? mask_q : '0;
  assign dense_latch_o       = state_q == LATCH;
  assign out_valid_o         = state_q == READ;
  assign dense_rd_addr_o     = state_q == READ ? rd_q[ADDR_W-1:0] : '0;
  assign tile_idx_o          = tile_q;
  assign done_o              = state_q == DONE;
  assign cfg_err_o           = state_q == DONE && cfg_err_q;
endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb_dense_seq_ctrl: randomized run schedules checked cycle by cycle against a phase-list model
module tb_dense_seq_ctrl;
  import dense_pkg::*;
  localparam int PAT = 2048;
  typedef struct packed {
    logic busy, en, rdy, dv;
    logic [15:0] ars, aon;
    logic lat;
    logic [3:0] ra;
    logic ov;
    logic [11:0] tile;
    logic dn, ce;
  } rec_t;
  logic clk = 0, rst = 1, start_i = 0, abort_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [15:0] in_len_i = 0;
  logic [11:0] num_tiles_i = 0;
  logic [4:0] active_pes_i = 0;
  logic in_ready_o, dense_enable_o, dense_valid_o, dense_latch_o, out_valid_o, busy_o, done_o, cfg_err_o;
  logic [15:0] dense_adder_reset_o, dense_adder_on_o;
  logic [3:0] dense_rd_addr_o;
  logic [11:0] tile_idx_o;
  always #5 clk = ~clk;
  dense_seq_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .in_len_i(in_len_i), .num_tiles_i(num_tiles_i), .active_pes_i(active_pes_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .dense_enable_o(dense_enable_o),
    .dense_valid_o(dense_valid_o), .dense_adder_reset_o(dense_adder_reset_o),
    .dense_adder_on_o(dense_adder_on_o), .dense_latch_o(dense_latch_o),
    .dense_rd_addr_o(dense_rd_addr_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .tile_idx_o(tile_idx_o), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
  );
  rec_t dut_r;
  assign dut_r = {busy_o, dense_enable_o, in_ready_o, dense_valid_o, dense_adder_reset_o,
                  dense_adder_on_o, dense_latch_o, dense_rd_addr_o, out_valid_o, tile_idx_o,
                  done_o, cfg_err_o};
  int checks = 0, failures = 0;
  bit iv_pat[PAT], or_pat[PAT];
  rec_t exp_q[$];
  logic [15:0] m_mask;
  int m_done_idx, n_dv, n_lat, n_rd, n_done, dut_done_idx;

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic bit ivp(input int k);
    return k < PAT ? iv_pat[k] : 1'b1;
  endfunction

  function automatic bit orp(input int k);
    return k < PAT ? or_pat[k] : 1'b1;
  endfunction

  task automatic fill(input int piv, input int por);
    for (int k = 0; k < PAT; k++) begin
      iv_pat[k] = $urandom_range(99) < piv;
      or_pat[k] = $urandom_range(99) < por;
    end
  endtask

  // expected outputs for every cycle after start, built phase by phase from the layer rules
  task automatic build(input int len, input int tiles, input int ap, output bit legal);
    rec_t r, b;
    int acc, rd;
    exp_q.delete();
    m_mask = '0;
    for (int i = 0; i < ap && i < 16; i++) m_mask[i] = 1'b1;
    legal = len > 0 && tiles > 0 && ap > 0 && ap <= 16;
    if (!legal) begin
      r = '0; r.busy = 1; r.dn = 1; r.ce = 1;
      m_done_idx = 0;
      exp_q.push_back(r);
    end else for (int t = 0; t < tiles; t++) begin
      b = '0; b.busy = 1; b.tile = 12'(t);
      r = b; r.en = 1; r.ars = m_mask; exp_q.push_back(r);
      acc = 0;
      while (acc < len) begin
        r = b; r.en = 1; r.rdy = 1; r.aon = m_mask; r.dv = ivp(exp_q.size());
        acc += int'(r.dv);
        exp_q.push_back(r);
      end
      repeat (MAC_LAT) begin r = b; r.en = 1; r.aon = m_mask; exp_q.push_back(r); end
      r = b; r.en = 1; r.lat = 1; exp_q.push_back(r);
      rd = 0;
      while (rd < ap) begin
        r = b; r.en = 1; r.ov = 1; r.ra = 4'(rd);
        if (orp(exp_q.size())) rd++;
        exp_q.push_back(r);
      end
      exp_q.push_back(b);
      if (t == tiles - 1) begin
        b.dn = 1; m_done_idx = exp_q.size(); exp_q.push_back(b);
      end
    end
    r = '0;
    exp_q.push_back(r);
  endtask

  task automatic run_layer(input int len, input int tiles, input int ap, input bit poke);
    bit legal;
    build(len, tiles, ap, legal);
    n_dv = 0; n_lat = 0; n_rd = 0; n_done = 0; dut_done_idx = -1;
    @(posedge clk); #1;
    start_i = 1; in_len_i = 16'(len); num_tiles_i = 12'(tiles); active_pes_i = 5'(ap);
    @(posedge clk); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      start_i = poke && k == 3;
      in_valid_i = ivp(k); out_ready_i = orp(k);
      in_len_i = 16'($urandom_range(0, 9)); num_tiles_i = 12'($urandom_range(0, 5));
      active_pes_i = 5'($urandom_range(0, 20));
      @(negedge clk);
      checks++;
      if (dut_r !== exp_q[k]) begin
        failures++;
        $display("FAIL cycle k=%0d (len=%0d tiles=%0d ap=%0d) got=%h want=%h",
                 k, len, tiles, ap, dut_r, exp_q[k]);
      end
      n_dv += int'(dense_valid_o);
      n_lat += int'(dense_latch_o);
      n_rd += int'(out_valid_o && out_ready_i);
      n_done += int'(done_o);
      if (done_o) dut_done_idx = k;
      @(posedge clk); #1;
    end
    start_i = 0; in_valid_i = 0; out_ready_i = 0;
    chk("done_count", n_done, 1);
    if (legal) begin
      chk("beats_accepted", n_dv, len * tiles);
      chk("latch_count", n_lat, tiles);
      chk("results_read", n_rd, ap * tiles);
    end
  endtask

  task automatic abort_in_drain();
    bit bad = 0;
    @(posedge clk); #1;
    start_i = 1; in_len_i = 2; num_tiles_i = 1; active_pes_i = 4; in_valid_i = 1; out_ready_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort_pre_aon", dense_adder_on_o, 16'h000F);
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    chk("abort_idle", dut_r, 0);
    repeat (6) begin @(negedge clk); bad |= done_o | dense_latch_o | busy_o; end
    chk("abort_quiet", bad, 0);
  endtask

  task automatic rst_in_read();
    @(posedge clk); #1;
    start_i = 1; in_len_i = 1; num_tiles_i = 1; active_pes_i = 8; in_valid_i = 1; out_ready_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("read_addr_before_rst", dense_rd_addr_o, 2);
    chk("read_valid_before_rst", out_valid_o, 1);
    #2 rst = 1;
    #1 chk("rst_immediate", dut_r, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_idle", dut_r, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", dut_r, 0);
    rst = 0;
    fill(100, 100);
    run_layer(4, 1, 16, 0);
    chk("model_done_idx", m_done_idx, 26);
    chk("dut_done_idx", dut_done_idx, 26);
    chk("mask16", m_mask, 16'hFFFF);
    fill(100, 0);
    for (int k = 0; k < PAT; k++) or_pat[k] = k % 2 == 1;
    iv_pat[1] = 1; iv_pat[2] = 0; iv_pat[3] = 0; iv_pat[4] = 1; iv_pat[5] = 1;
    run_layer(3, 1, 6, 0);
    fill(70, 70);
    run_layer(3, 3, 5, 0);
    chk("mask5", m_mask, 16'h001F);
    run_layer(0, 2, 4, 0);
    chk("cfg_err_done_idx", dut_done_idx, 0);
    run_layer(2, 1, 17, 0);
    run_layer(2, 0, 4, 0);
    abort_in_drain();
    fill(100, 100);
    run_layer(2, 1, 4, 0);
    rst_in_read();
    run_layer(2, 2, 3, 0);
    fill(80, 80);
    run_layer(3, 2, 4, 1);
    repeat (20) begin
      fill($urandom_range(30, 100), $urandom_range(30, 100));
      run_layer($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(1, 16),
                1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
